// File: rtl/lcd_bus_writer.sv
// HD44780-style bus write generator: one RS/RW/E/DB write cycle per request,
// with programmable setup, E-pulse, hold, nibble-gap and execution-wait timing.
module lcd_bus_writer #(
    parameter int unsigned SETUP_CYC      = 2,
    parameter int unsigned E_HIGH_CYC     = 12,
    parameter int unsigned HOLD_CYC       = 1,
    parameter int unsigned NIBBLE_GAP_CYC = 50,
    parameter int unsigned SHORT_WAIT_CYC = 1850,
    parameter int unsigned LONG_WAIT_CYC  = 76000,
    parameter int unsigned CNT_W          = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_enable,
    input  logic       reg_sel,
    input  logic [7:0] data_in,
    input  logic       mode_4bit,
    input  logic       wait_long,
    output logic       e_out,
    output logic       rs_out,
    output logic       rw_out,
    output logic [7:0] db_out,
    output logic       busy,
    output logic       wr_finish
);

    localparam longint unsigned CNT_LIM = 64'(1) << CNT_W;

    // Every duration must be nonzero and its (duration-1) must fit the counter.
    if (SETUP_CYC < 1 || E_HIGH_CYC < 1 || HOLD_CYC < 1 || NIBBLE_GAP_CYC < 1 ||
        SHORT_WAIT_CYC < 1 || LONG_WAIT_CYC < 1) begin : g_bad_duration
        $error("lcd_bus_writer: all cycle parameters must be >= 1");
    end
    if (64'(SETUP_CYC) > CNT_LIM || 64'(E_HIGH_CYC) > CNT_LIM ||
        64'(HOLD_CYC) > CNT_LIM || 64'(NIBBLE_GAP_CYC) > CNT_LIM ||
        64'(SHORT_WAIT_CYC) > CNT_LIM || 64'(LONG_WAIT_CYC) > CNT_LIM) begin : g_bad_cnt_w
        $error("lcd_bus_writer: CNT_W too narrow for the configured durations");
    end

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EHIGH_LD = CNT_W'(E_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(NIBBLE_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(SHORT_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_EHIGH, S_HOLD, S_GAP, S_WAIT, S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             nib_q, nib_d;
    logic [7:0]       data_q, data_d;
    logic             m4_q, m4_d;
    logic             long_q, long_d;
    logic             rs_q, rs_d;
    logic [7:0]       db_q, db_d;
    logic             e_q, e_d;
    logic             busy_q, busy_d;
    logic             fin_q, fin_d;

    // Byte presented on DB for the given mode and nibble phase (upper nibble first).
    function automatic logic [7:0] bus_byte(input logic [7:0] b, input logic m4,
                                            input logic second);
        if (!m4)
            return b;
        else if (second)
            return {b[3:0], 4'h0};
        else
            return {b[7:4], 4'h0};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nib_d   = nib_q;
        data_d  = data_q;
        m4_d    = m4_q;
        long_d  = long_q;
        rs_d    = rs_q;
        db_d    = db_q;

        unique case (state_q)
            S_IDLE: begin
                if (wr_enable) begin
                    data_d  = data_in;
                    m4_d    = mode_4bit;
                    long_d  = wait_long;
                    nib_d   = 1'b0;
                    rs_d    = reg_sel;
                    db_d    = bus_byte(data_in, mode_4bit, 1'b0);
                    cnt_d   = SETUP_LD;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    cnt_d   = EHIGH_LD;
                    state_d = S_EHIGH;
                end
            end
            S_EHIGH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    cnt_d   = HOLD_LD;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (m4_q && !nib_q) begin
                    cnt_d   = GAP_LD;
                    state_d = S_GAP;
                end else begin
                    cnt_d   = long_q ? LONG_LD : SHORT_LD;
                    state_d = S_WAIT;
                end
            end
            S_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    nib_d   = 1'b1;
                    db_d    = bus_byte(data_q, m4_q, 1'b1);
                    cnt_d   = SETUP_LD;
                    state_d = S_SETUP;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Strobes derive from the next state so the registered pins line up with it.
        e_d    = (state_d == S_EHIGH);
        busy_d = (state_d != S_IDLE);
        fin_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            nib_q   <= 1'b0;
            data_q  <= '0;
            m4_q    <= 1'b0;
            long_q  <= 1'b0;
            rs_q    <= 1'b0;
            db_q    <= '0;
            e_q     <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nib_q   <= nib_d;
            data_q  <= data_d;
            m4_q    <= m4_d;
            long_q  <= long_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            e_q     <= e_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
        end
    end

    assign e_out     = e_q;
    assign rs_out    = rs_q;
    assign rw_out    = 1'b0;
    assign db_out    = db_q;
    assign busy      = busy_q;
    assign wr_finish = fin_q;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Directed bench for lcd_bus_writer with short timing parameters; checks the
// full pin trace of each write cycle by cycle against hand-computed windows.
module tb_lcd_bus_writer;

    localparam int unsigned SETUP = 2;
    localparam int unsigned EHIGH = 3;
    localparam int unsigned HOLD  = 1;
    localparam int unsigned GAP   = 4;
    localparam int unsigned SHORT = 5;
    localparam int unsigned LONG  = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_enable;
    logic       reg_sel;
    logic [7:0] data_in;
    logic       mode_4bit;
    logic       wait_long;
    logic       e_out;
    logic       rs_out;
    logic       rw_out;
    logic [7:0] db_out;
    logic       busy;
    logic       wr_finish;

    int checks = 0;
    int errors = 0;

    lcd_bus_writer #(
        .SETUP_CYC(SETUP), .E_HIGH_CYC(EHIGH), .HOLD_CYC(HOLD),
        .NIBBLE_GAP_CYC(GAP), .SHORT_WAIT_CYC(SHORT), .LONG_WAIT_CYC(LONG),
        .CNT_W(17)
    ) dut (
        .clk(clk), .rst(rst), .wr_enable(wr_enable), .reg_sel(reg_sel),
        .data_in(data_in), .mode_4bit(mode_4bit), .wait_long(wait_long),
        .e_out(e_out), .rs_out(rs_out), .rw_out(rw_out), .db_out(db_out),
        .busy(busy), .wr_finish(wr_finish)
    );

    always #5 clk = ~clk;

    // Cycle 0 is the cycle the request is presented; cycle k is sampled after edge k-1.
    typedef struct {
        string      name;
        logic       rs;
        logic [7:0] data;
        logic       m4;
        logic       lng;
        logic       tog;
        int         e2_lo;
        int         sw;
        logic [7:0] db1;
        logic [7:0] db2;
        int         fin;
    } vec_t;

    vec_t vecs[6];

    task automatic check_out(input string name, input int k, input logic [12:0] exp);
        logic [12:0] got;
        got = {e_out, busy, wr_finish, rs_out, rw_out, db_out};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got e/busy/fin/rs/rw/db=%b want %b", name, k, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic drive_req(input vec_t v);
        reg_sel   = v.rs;
        data_in   = v.data;
        mode_4bit = v.m4;
        wait_long = v.lng;
        wr_enable = 1'b1;
    endtask

    // Expects the cycle-0 request already driven at the current negedge.
    task automatic run_trace(input vec_t v);
        int         fin_seen;
        logic       exp_e;
        logic [7:0] exp_db;
        fin_seen = 0;
        for (int k = 1; k <= v.fin + 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_e  = (k >= 3 && k <= 5) || (v.e2_lo != 0 && k >= v.e2_lo && k <= v.e2_lo + 2);
            exp_db = (v.sw != 0 && k >= v.sw) ? v.db2 : v.db1;
            check_out(v.name, k, {exp_e, (k <= v.fin), (k == v.fin), v.rs, 1'b0, exp_db});
            if (wr_finish) fin_seen++;
            if (v.tog && k < v.fin) begin
                wr_enable = k[0];
                data_in   = 8'($urandom);
                mode_4bit = ~mode_4bit;
                wait_long = ~wait_long;
                reg_sel   = ~reg_sel;
            end else begin
                wr_enable = 1'b0;
            end
        end
        check_int({v.name, " finish count"}, fin_seen, 1);
    endtask

    initial begin
        int         fin_seen;
        logic       exp_e;

        vecs[0] = '{"8b_short_38", 1'b0, 8'h38, 1'b0, 1'b0, 1'b0, 0,  0,  8'h38, 8'h00, 12};
        vecs[1] = '{"4b_data_A5",  1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 13, 11, 8'hA0, 8'h50, 22};
        vecs[2] = '{"8b_long_01",  1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 0,  0,  8'h01, 8'h00, 27};
        vecs[3] = '{"4b_long_3C",  1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 13, 11, 8'h30, 8'hC0, 37};
        vecs[4] = '{"8b_data_FF",  1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 0,  0,  8'hFF, 8'h00, 12};
        vecs[5] = '{"toggle_38",   1'b0, 8'h38, 1'b0, 1'b0, 1'b1, 0,  0,  8'h38, 8'h00, 12};

        rst       = 1'b0;
        wr_enable = 1'b0;
        reg_sel   = 1'b0;
        data_in   = 8'h00;
        mode_4bit = 1'b0;
        wait_long = 1'b0;
        repeat (2) @(negedge clk);
        check_out("reset_state", 0, 13'h0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_out("idle_after_reset", 0, 13'h0);

        for (int i = 0; i < 6; i++) begin
            drive_req(vecs[i]);
            run_trace(vecs[i]);
        end

        // wr_enable held high: second write accepted by the first IDLE cycle (13).
        drive_req(vecs[0]);
        fin_seen = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_e = (k >= 3 && k <= 5) || (k >= 16 && k <= 18);
            check_out("back_to_back", k,
                      {exp_e, (k != 13 && k <= 25), (k == 12 || k == 25), 1'b0, 1'b0, 8'h38});
            if (wr_finish) fin_seen++;
            if (k >= 25) wr_enable = 1'b0;
        end
        check_int("back_to_back finish count", fin_seen, 2);

        // Reset during E_HIGH clears every pin at once and abandons the write.
        drive_req(vecs[1]);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_out("pre_reset_ehigh", 4, {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA0});
        rst       = 1'b0;
        wr_enable = 1'b0;
        #1;
        check_out("reset_mid_pulse", 4, 13'h0);
        for (int k = 5; k <= 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_out("held_in_reset", k, 13'h0);
        end
        // Request already pending when reset releases starts on the next edge.
        drive_req(vecs[0]);
        rst = 1'b1;
        run_trace(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
